// File: rtl/qam_stream_mapper.sv
// Byte-stream to QPSK/16QAM/64QAM symbol mapper: buffers input bits MSB-first
// and emits Gray-mapped, scaled and saturated I/Q levels on each symbol strobe.
module qam_stream_mapper #(
  parameter int unsigned WIDTH = 18,
  parameter int unsigned BUF_W = 16
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [1:0]              mode,
  input  logic signed [WIDTH-1:0] reference_level,
  input  logic                    sym_en,
  input  logic [7:0]              in_data,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic signed [WIDTH-1:0] i_out,
  output logic signed [WIDTH-1:0] q_out,
  output logic                    out_valid,
  output logic                    underflow
);

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned CNT_W  = $clog2(BUF_W + 1);
  localparam int unsigned EXT_W  = WIDTH + 3;

  localparam logic [1:0] MODE_QPSK  = 2'd0;
  localparam logic [1:0] MODE_QAM16 = 2'd1;
  localparam logic [1:0] MODE_QAM64 = 2'd2;

  localparam logic signed [EXT_W-1:0] SAT_MAX = {{4{1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [EXT_W-1:0] SAT_MIN = {{4{1'b1}}, {(WIDTH-1){1'b0}}};

  // Signed axis level +/-(2m+1)*h from k Gray-coded bits (right-aligned in bits).
  function automatic logic signed [EXT_W-1:0] map_axis(
    input logic [2:0]              bits,
    input logic [1:0]              k,
    input logic signed [EXT_W-1:0] h
  );
    logic                    pos;
    logic [1:0]              g;
    logic [1:0]              m;
    logic signed [EXT_W-1:0] mag;
    g = 2'b00;
    case (k)
      2'd1: begin
        pos = bits[0];
        m   = 2'd0;
      end
      2'd2: begin
        pos = bits[1];
        m   = {1'b0, ~bits[0]};
      end
      default: begin
        pos = bits[2];
        g   = ~bits[1:0];
        m   = {g[1], g[1] ^ g[0]};
      end
    endcase
    case (m)
      2'd0:    mag = h;
      2'd1:    mag = h + (h <<< 1);
      2'd2:    mag = (h <<< 2) + h;
      default: mag = (h <<< 3) - h;
    endcase
    return pos ? mag : -mag;
  endfunction

  function automatic logic signed [WIDTH-1:0] saturate(input logic signed [EXT_W-1:0] v);
    if (v > SAT_MAX) begin
      return SAT_MAX[WIDTH-1:0];
    end else if (v < SAT_MIN) begin
      return SAT_MIN[WIDTH-1:0];
    end
    return v[WIDTH-1:0];
  endfunction

  logic [CNT_W-1:0]        cnt_q, cnt_d, cnt_a;
  logic [BUF_W-1:0]        buf_q, buf_d, buf_a;
  logic [1:0]              mode_q, mode_d, mode_n;
  logic signed [WIDTH-1:0] i_d, q_d;
  logic                    out_valid_d, underflow_d;

  logic                    flush;
  logic [CNT_W-1:0]        bps;
  logic [1:0]              k;
  logic [5:0]              sym;
  logic [2:0]              i_bits, q_bits;
  logic signed [WIDTH-1:0] h;
  logic signed [EXT_W-1:0] h_ext, i_lvl, q_lvl;
  logic [BUF_W-1:0]        byte_al;

  // Next-state and handshake logic for the bit buffer and output samples.
  always_comb begin
    cnt_d       = cnt_q;
    buf_d       = buf_q;
    mode_d      = mode_q;
    i_d         = i_out;
    q_d         = q_out;
    out_valid_d = 1'b0;
    underflow_d = 1'b0;
    cnt_a       = cnt_q;
    buf_a       = buf_q;

    mode_n   = (mode == 2'd3) ? MODE_QAM16 : mode;
    flush    = (mode_n != mode_q);
    in_ready = (cnt_q <= CNT_W'(BUF_W - BYTE_W)) && !flush;

    case (mode_q)
      MODE_QPSK:  bps = CNT_W'(2);
      MODE_QAM64: bps = CNT_W'(6);
      default:    bps = CNT_W'(4);
    endcase

    sym = buf_q[BUF_W-1 -: 6];
    case (mode_q)
      MODE_QPSK: begin
        k      = 2'd1;
        i_bits = {2'b00, sym[5]};
        q_bits = {2'b00, sym[4]};
      end
      MODE_QAM64: begin
        k      = 2'd3;
        i_bits = sym[5:3];
        q_bits = sym[2:0];
      end
      default: begin
        k      = 2'd2;
        i_bits = {1'b0, sym[5:4]};
        q_bits = {1'b0, sym[3:2]};
      end
    endcase

    h       = reference_level >>> 1;
    h_ext   = {{3{h[WIDTH-1]}}, h};
    i_lvl   = map_axis(i_bits, k, h_ext);
    q_lvl   = map_axis(q_bits, k, h_ext);
    byte_al = {in_data, {(BUF_W-BYTE_W){1'b0}}};

    if (flush) begin
      // A mode change drops any partial symbol and blocks input for this cycle.
      cnt_d  = '0;
      buf_d  = '0;
      mode_d = mode_n;
      if (sym_en) begin
        i_d         = '0;
        q_d         = '0;
        underflow_d = 1'b1;
      end
    end else begin
      if (sym_en) begin
        if (cnt_q >= bps) begin
          cnt_a       = cnt_q - bps;
          buf_a       = buf_q << bps;
          i_d         = saturate(i_lvl);
          q_d         = saturate(q_lvl);
          out_valid_d = 1'b1;
        end else begin
          i_d         = '0;
          q_d         = '0;
          underflow_d = 1'b1;
        end
      end
      // New byte lands directly behind the bits left after any consume.
      if (in_valid && in_ready) begin
        buf_d = buf_a | (byte_al >> cnt_a);
        cnt_d = cnt_a + CNT_W'(BYTE_W);
      end else begin
        buf_d = buf_a;
        cnt_d = cnt_a;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q     <= '0;
      buf_q     <= '0;
      mode_q    <= MODE_QAM16;
      i_out     <= '0;
      q_out     <= '0;
      out_valid <= 1'b0;
      underflow <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      buf_q     <= buf_d;
      mode_q    <= mode_d;
      i_out     <= i_d;
      q_out     <= q_d;
      out_valid <= out_valid_d;
      underflow <= underflow_d;
    end
  end

endmodule

// File: tb/tb_qam_stream_mapper.sv
// Directed bench for qam_stream_mapper: a bit-level model pushes expected symbols
// into a scoreboard queue on each strobe; they are popped when the DUT responds.
module tb_qam_stream_mapper;

  localparam int W = 18;

  logic                clk = 1'b0;
  logic                reset_n;
  logic [1:0]          mode;
  logic signed [W-1:0] reference_level;
  logic                sym_en;
  logic [7:0]          in_data;
  logic                in_valid;
  logic                in_ready;
  logic signed [W-1:0] i_out;
  logic signed [W-1:0] q_out;
  logic                out_valid;
  logic                underflow;

  always #5 clk = ~clk;

  qam_stream_mapper #(.WIDTH(W), .BUF_W(16)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .mode            (mode),
    .reference_level (reference_level),
    .sym_en          (sym_en),
    .in_data         (in_data),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .i_out           (i_out),
    .q_out           (q_out),
    .out_valid       (out_valid),
    .underflow       (underflow)
  );

  typedef struct {
    logic uf;
    int   i;
    int   q;
  } exp_t;

  exp_t exp_q[$];
  bit   bq[$];
  int   mr     = 1;
  int   last_i = 0;
  int   last_q = 0;
  int   n_cmp  = 0;
  int   n_err  = 0;

  function automatic int sat18(input int v);
    if (v > 131071) return 131071;
    if (v < -131072) return -131072;
    return v;
  endfunction

  // Axis level straight from the level tables: QPSK +/-h, 16QAM and 64QAM Gray orders.
  function automatic int exp_axis(input int k, input int bits, input int r);
    int h;
    int mag;
    int pos;
    h = r >>> 1;
    if (k == 1) begin
      pos = bits;
      mag = 1;
    end else if (k == 2) begin
      pos = (bits >> 1) & 1;
      mag = ((bits & 1) == 1) ? 1 : 3;
    end else begin
      pos = (bits >> 2) & 1;
      case (bits & 3)
        3:       mag = 1;
        2:       mag = 3;
        0:       mag = 5;
        default: mag = 7;
      endcase
    end
    return sat18((pos != 0) ? mag * h : -mag * h);
  endfunction

  task automatic chk(input string tag, input logic signed [31:0] got,
                     input logic signed [31:0] expv);
    n_cmp++;
    assert (got === expv) else begin
      n_err++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, got, expv);
    end
  endtask

  // One clock: drive inputs, check in_ready, update model, then check registered outputs.
  task automatic tick(input logic se, input logic iv, input logic [7:0] d);
    int   nm;
    int   k;
    int   ib;
    int   qb;
    logic fl;
    logic rdy;
    exp_t e;
    sym_en   = se;
    in_valid = iv;
    in_data  = d;
    #1;
    nm  = (mode == 2'd3) ? 1 : int'(mode);
    fl  = (nm != mr);
    rdy = (bq.size() <= 8) && !fl;
    chk("in_ready", in_ready, rdy);
    k = (mr == 0) ? 1 : ((mr == 2) ? 3 : 2);
    if (se) begin
      if (!fl && bq.size() >= 2 * k) begin
        ib = 0;
        qb = 0;
        for (int j = 0; j < k; j++) ib = (ib << 1) | int'(bq.pop_front());
        for (int j = 0; j < k; j++) qb = (qb << 1) | int'(bq.pop_front());
        e.uf = 1'b0;
        e.i  = exp_axis(k, ib, int'(reference_level));
        e.q  = exp_axis(k, qb, int'(reference_level));
      end else begin
        e.uf = 1'b1;
        e.i  = 0;
        e.q  = 0;
      end
      exp_q.push_back(e);
    end
    if (fl) begin
      bq.delete();
      mr = nm;
    end else if (iv && rdy) begin
      for (int j = 7; j >= 0; j--) bq.push_back(d[j]);
    end
    @(posedge clk);
    #1;
    if (se) begin
      e = exp_q.pop_front();
      chk("out_valid", out_valid, !e.uf);
      chk("underflow", underflow, e.uf);
      chk("i_out", $signed(i_out), e.i);
      chk("q_out", $signed(q_out), e.q);
      last_i = e.i;
      last_q = e.q;
    end else begin
      chk("idle_out_valid", out_valid, 1'b0);
      chk("idle_underflow", underflow, 1'b0);
      chk("hold_i", $signed(i_out), last_i);
      chk("hold_q", $signed(q_out), last_q);
    end
  endtask

  initial begin
    reset_n         = 1'b0;
    mode            = 2'd1;
    reference_level = 18'sd65536;
    sym_en          = 1'b0;
    in_valid        = 1'b0;
    in_data         = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_i", $signed(i_out), 0);
    chk("rst_q", $signed(q_out), 0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_underflow", underflow, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);
    reset_n = 1'b1;

    // 16QAM, 0x1E -> two symbols
    tick(1'b0, 1'b1, 8'h1E);
    tick(1'b1, 1'b0, 8'h00);
    chk("q16_s1_i", $signed(i_out), -98304);
    chk("q16_s1_q", $signed(q_out), -32768);
    tick(1'b1, 1'b0, 8'h00);
    chk("q16_s2_i", $signed(i_out), 32768);
    chk("q16_s2_q", $signed(q_out), 98304);
    tick(1'b0, 1'b0, 8'h00);

    // Underflow on empty buffer
    tick(1'b1, 1'b0, 8'h00);
    chk("uf_pulse", underflow, 1'b1);

    // QPSK, 0xA5 -> four symbols (first cycle is the flush)
    mode = 2'd0;
    tick(1'b0, 1'b1, 8'hA5);
    tick(1'b0, 1'b1, 8'hA5);
    tick(1'b1, 1'b0, 8'h00);
    chk("qpsk_s1_i", $signed(i_out), 32768);
    chk("qpsk_s1_q", $signed(q_out), -32768);
    repeat (3) tick(1'b1, 1'b0, 8'h00);
    chk("qpsk_s4_i", $signed(i_out), -32768);

    // 64QAM, R=32768, 0x86 then carry of two bits into the next byte
    mode            = 2'd2;
    reference_level = 18'sd32768;
    tick(1'b0, 1'b0, 8'h00);
    tick(1'b0, 1'b1, 8'h86);
    tick(1'b1, 1'b0, 8'h00);
    chk("q64_i", $signed(i_out), 81920);
    chk("q64_q", $signed(q_out), -114688);
    tick(1'b1, 1'b1, 8'h3C);
    tick(1'b1, 1'b0, 8'h00);
    tick(1'b1, 1'b0, 8'h00);

    // 64QAM saturation, R=65536, symbol 101_001
    mode = 2'd1;
    tick(1'b0, 1'b0, 8'h00);
    mode            = 2'd2;
    reference_level = 18'sd65536;
    tick(1'b0, 1'b0, 8'h00);
    tick(1'b0, 1'b1, 8'hA4);
    tick(1'b1, 1'b0, 8'h00);
    chk("sat_i", $signed(i_out), 131071);
    chk("sat_q", $signed(q_out), -131072);

    // Back-pressure and simultaneous accept+consume in 16QAM
    mode = 2'd1;
    tick(1'b0, 1'b0, 8'h00);
    tick(1'b0, 1'b1, 8'h5A);
    tick(1'b0, 1'b1, 8'hC3);
    tick(1'b0, 1'b1, 8'hFF);
    tick(1'b1, 1'b1, 8'h77);
    tick(1'b1, 1'b1, 8'h77);
    tick(1'b1, 1'b1, 8'h96);
    repeat (3) tick(1'b1, 1'b0, 8'h00);
    tick(1'b1, 1'b0, 8'h00);

    // Mode switch with 4 bits buffered, strobe during flush
    tick(1'b0, 1'b1, 8'h3C);
    tick(1'b1, 1'b0, 8'h00);
    mode = 2'd0;
    tick(1'b1, 1'b1, 8'hFF);
    tick(1'b1, 1'b0, 8'h00);
    tick(1'b0, 1'b1, 8'h0F);
    tick(1'b1, 1'b0, 8'h00);

    // Reserved mode behaves as 16QAM
    mode = 2'd3;
    tick(1'b0, 1'b1, 8'h1E);
    tick(1'b0, 1'b1, 8'h1E);
    tick(1'b1, 1'b0, 8'h00);

    // Asynchronous reset mid-stream
    tick(1'b0, 1'b1, 8'hE1);
    tick(1'b1, 1'b0, 8'h00);
    #1;
    reset_n = 1'b0;
    #1;
    chk("arst_i", $signed(i_out), 0);
    chk("arst_q", $signed(q_out), 0);
    chk("arst_out_valid", out_valid, 1'b0);
    chk("arst_underflow", underflow, 1'b0);
    bq.delete();
    exp_q.delete();
    mr     = 1;
    last_i = 0;
    last_q = 0;
    mode   = 2'd1;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    tick(1'b0, 1'b0, 8'h00);
    tick(1'b1, 1'b0, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
